psr_flag_unit: RTL
==================

// Module: psr_flag_unit
// PURPOSE
//  Processor status register downstream of the ALU: latches its 5-bit flags on flag-writing ops.
//  Feeds carry back to the ALU Cin, serves LPR/SPR PSR moves and evaluates 4-bit branch/jump conditions.
//  Sits between execute and fetch/branch control; single clock domain.
// PARAMETERS
//  FLAG_W    5   ALU flag width: [0]C carry, [1]L unsigned-less, [2]F overflow, [3]Z equal, [4]N signed-less
//  PSR_W     16  width of PSR read/write data bus
// PORTS
//  clk           in   1       system clock, all state updates on rising edge
//  reset         in   1       synchronous, active-high
//  alu_flags     in   FLAG_W  flags from ALU, current execute op
//  flag_we       in   1       execute op updates PSR (arith/cmp/logic ops)
//  psr_wr_en     in   1       LPR: load PSR from psr_wr_data
//  psr_wr_data   in   PSR_W   LPR data; only [FLAG_W-1:0] used
//  psr_rd_data   out  PSR_W   {zeros, psr}, combinational from register (SPR)
//  cin           out  1       psr[0], combinational, to ALU Cin
//  cond_valid    in   1       branch condition request this cycle
//  cond          in   4       condition code
//  cond_done     out  1       one-cycle pulse, cycle after cond_valid
//  cond_true     out  1       registered result, held until next cond_done
//  int_save      in   1       interrupt entry (PSR_SHADOW_EN only)
//  int_restore   in   1       interrupt return (PSR_SHADOW_EN only)
// BEHAVIOUR
//  - Reset: psr=0, cond_done=0, cond_true=0, shadow=0; cin=0, psr_rd_data=0 follow.
//  - Reset mid-request: a pending cond_done is dropped, no pulse after reset.
//  - psr_next priority: reset > int_restore > psr_wr_en > flag_we > hold.
//  - flag_we: psr<=alu_flags. psr_wr_en: psr<=psr_wr_data[4:0]. Upper bits ignored.
//  - Both psr_wr_en and flag_we set in one cycle: LPR wins, ALU flags discarded.
//  - Condition eval uses psr_next (bypass): a CMP with flag_we in the same cycle as cond_valid is seen.
//  - Latency: cond_valid in cycle N -> cond_done=1 and cond_true valid in N+1.
//  - Back-to-back cond_valid: one pulse per request, cond_done stays high.
//  - Codes: 0000 EQ Z, 0001 NE !Z, 0010 CS C, 0011 CC !C, 0100 LO L, 0101 HS !L, 0110 LT N, 0111 GE !N,
//    1000 GT !N&!Z, 1001 LE N|Z, 1010 HI !L&!Z, 1011 LS L|Z, 1100 FS F, 1101 FC !F, 1110 UC 1, 1111 NV 0.
//  - cond ignored when cond_valid=0; cond_true keeps its last value.
// CONFIGURATION
//  PSR_SHADOW_EN defined:
//   - 5-bit shadow register present.
//   - int_save: shadow<=psr_next; psr itself is unchanged by int_save.
//   - int_restore: psr<=shadow.
//   - Both int_save and int_restore high: restore wins, shadow unchanged.
//  PSR_SHADOW_EN undefined:
//   - int_save and int_restore stay in the port list but are ignored.
//   - No shadow storage; priority reduces to reset > psr_wr_en > flag_we.
// STRUCTURE
//  - psr_pkg: flag bit index localparams (FLAG_C..FLAG_N), 4-bit condition code localparams (COND_EQ..COND_NV),
//    FLAG_W.
//  - One sub-module, psr_cond_eval: combinational (flags[4:0], cond[3:0]) -> taken.
//  - Top module holds psr, shadow, the next-state mux and the cond_done/cond_true registers.
// TESTING
//  1 Reset high 2 cycles with flag_we=1, alu_flags=5'h1F -> psr_rd_data=16'h0000, cin=0, cond_done=0.
//  2 flag_we=1, alu_flags=5'b01000 with cond_valid=1, cond=0000 same cycle -> next cycle cond_done=1,
//    cond_true=1, psr_rd_data=16'h0008.
//  3 psr_wr_en=1, psr_wr_data=16'hFFE1 and flag_we=1, alu_flags=5'b10000 -> psr_rd_data=16'h0001, cin=1.
//  4 psr=5'b10000, cond=1000 (GT) -> cond_true=0; cond=1001 (LE) -> 1; cond=1111 (NV) -> 0.
//    Each request gets its own cond_done pulse.
//  5 cond_valid=1 then reset=1 next cycle -> cond_done=0 and cond_true=0 that cycle.
//  6 (PSR_SHADOW_EN) psr=5'h05, int_save; flag_we 5'h1A; int_restore -> psr_rd_data=16'h0005.
//    Repeat with save and restore asserted together -> shadow unchanged.

Source files
------------

// File: rtl/psr_flag_unit_pkg.sv
// Package: psr_flag_unit_pkg
// Shared widths, flag bit positions and branch condition codes for the
// processor status register block.
package psr_flag_unit_pkg;

    // Widths of the ALU flag vector and of the PSR move bus
    localparam int FLAG_W = 5;
    localparam int PSR_W  = 16;

    // Flag bit positions inside the PSR
    localparam int FLAG_C = 0;  // carry
    localparam int FLAG_L = 1;  // unsigned less-than
    localparam int FLAG_F = 2;  // signed overflow
    localparam int FLAG_Z = 3;  // equal / zero
    localparam int FLAG_N = 4;  // signed less-than

    // Branch / jump condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_LO = 4'b0100;
    localparam logic [3:0] COND_HS = 4'b0101;
    localparam logic [3:0] COND_LT = 4'b0110;
    localparam logic [3:0] COND_GE = 4'b0111;
    localparam logic [3:0] COND_GT = 4'b1000;
    localparam logic [3:0] COND_LE = 4'b1001;
    localparam logic [3:0] COND_HI = 4'b1010;
    localparam logic [3:0] COND_LS = 4'b1011;
    localparam logic [3:0] COND_FS = 4'b1100;
    localparam logic [3:0] COND_FC = 4'b1101;
    localparam logic [3:0] COND_UC = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/psr_flag_unit_if.sv
// Interface: psr_flag_unit_if
// Bundles the execute-stage flag inputs, the LPR/SPR move bus, the branch
// condition request/response and the interrupt save/restore strobes.
// The master side is execute/branch control, the slave side is the PSR unit.
interface psr_flag_unit_if;
    import psr_flag_unit_pkg::*;

    logic [FLAG_W-1:0] alu_flags;
    logic              flag_we;
    logic              psr_wr_en;
    logic [PSR_W-1:0]  psr_wr_data;
    logic [PSR_W-1:0]  psr_rd_data;
    logic              cin;
    logic              cond_valid;
    logic [3:0]        cond;
    logic              cond_done;
    logic              cond_true;
    logic              int_save;
    logic              int_restore;

    modport master (
        output alu_flags, flag_we, psr_wr_en, psr_wr_data,
        output cond_valid, cond, int_save, int_restore,
        input  psr_rd_data, cin, cond_done, cond_true
    );

    modport slave (
        input  alu_flags, flag_we, psr_wr_en, psr_wr_data,
        input  cond_valid, cond, int_save, int_restore,
        output psr_rd_data, cin, cond_done, cond_true
    );

endinterface

// File: rtl/psr_flag_unit_cond_eval.sv
// Module: psr_flag_unit_cond_eval
// Purely combinational branch condition evaluator: maps a flag vector and a
// 4-bit condition code to a taken/not-taken decision.
module psr_flag_unit_cond_eval
    import psr_flag_unit_pkg::*;
(
    input  logic [FLAG_W-1:0] i_flags,
    input  logic [3:0]        i_cond,
    output logic              o_taken
);

    logic w_c, w_l, w_f, w_z, w_n;

    assign w_c = i_flags[FLAG_C];
    assign w_l = i_flags[FLAG_L];
    assign w_f = i_flags[FLAG_F];
    assign w_z = i_flags[FLAG_Z];
    assign w_n = i_flags[FLAG_N];

    // Decode the condition code against the individual flags
    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            COND_EQ: o_taken =  w_z;
            COND_NE: o_taken = ~w_z;
            COND_CS: o_taken =  w_c;
            COND_CC: o_taken = ~w_c;
            COND_LO: o_taken =  w_l;
            COND_HS: o_taken = ~w_l;
            COND_LT: o_taken =  w_n;
            COND_GE: o_taken = ~w_n;
            COND_GT: o_taken = ~w_n & ~w_z;
            COND_LE: o_taken =  w_n |  w_z;
            COND_HI: o_taken = ~w_l & ~w_z;
            COND_LS: o_taken =  w_l |  w_z;
            COND_FS: o_taken =  w_f;
            COND_FC: o_taken = ~w_f;
            COND_UC: o_taken = 1'b1;
            COND_NV: o_taken = 1'b0;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/psr_flag_unit.sv
// Module: psr_flag_unit
// Processor status register sitting after the ALU. Latches ALU flags on
// flag-writing ops, supports LPR/SPR moves, feeds carry back to the ALU and
// answers branch condition requests one cycle later. Condition evaluation
// looks at the next-state PSR so a compare in the same cycle is visible.
// Optional feature macro: PSR_SHADOW_EN adds a one-deep shadow copy of the
// PSR for interrupt entry/return. Without it int_save/int_restore are ignored.
module psr_flag_unit
    import psr_flag_unit_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    psr_flag_unit_if.slave psr_if
);

    logic [FLAG_W-1:0] r_psr;
    logic [FLAG_W-1:0] w_psr_next;
    logic [FLAG_W-1:0] w_shadow_val;
    logic              w_restore;
    logic              w_taken;
    logic              r_cond_done;
    logic              r_cond_true;
    logic              w_unused_wr_hi;

    // Only the low flag bits of an LPR carry information
    assign w_unused_wr_hi = ^psr_if.psr_wr_data[PSR_W-1:FLAG_W];

`ifdef PSR_SHADOW_EN
    logic [FLAG_W-1:0] r_shadow;
    logic              w_save;

    assign w_restore    = psr_if.int_restore;
    // A simultaneous restore takes priority and leaves the shadow untouched
    assign w_save       = psr_if.int_save & ~psr_if.int_restore;
    assign w_shadow_val = r_shadow;

    // Shadow captures the PSR value as it will be after this cycle's updates
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow <= '0;
        end else if (w_save) begin
            r_shadow <= w_psr_next;
        end
    end
`else
    logic w_unused_int;

    assign w_unused_int = psr_if.int_save ^ psr_if.int_restore;
    assign w_restore    = 1'b0;
    assign w_shadow_val = '0;
`endif

    // Next-state selection: restore, then LPR, then ALU flags, else hold
    always_comb begin
        w_psr_next = r_psr;
        if (w_restore) begin
            w_psr_next = w_shadow_val;
        end else if (psr_if.psr_wr_en) begin
            w_psr_next = psr_if.psr_wr_data[FLAG_W-1:0];
        end else if (psr_if.flag_we) begin
            w_psr_next = psr_if.alu_flags;
        end
    end

    psr_flag_unit_cond_eval u_cond_eval (
        .i_flags (w_psr_next),
        .i_cond  (psr_if.cond),
        .o_taken (w_taken)
    );

    // PSR register update
    always_ff @(posedge clk) begin
        if (reset) begin
            r_psr <= '0;
        end else begin
            r_psr <= w_psr_next;
        end
    end

    // Condition response: done pulses per request, result held between requests
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cond_done <= 1'b0;
            r_cond_true <= 1'b0;
        end else begin
            r_cond_done <= psr_if.cond_valid;
            if (psr_if.cond_valid) begin
                r_cond_true <= w_taken;
            end
        end
    end

    assign psr_if.psr_rd_data = {{(PSR_W-FLAG_W){1'b0}}, r_psr};
    assign psr_if.cin         = r_psr[FLAG_C];
    assign psr_if.cond_done   = r_cond_done;
    assign psr_if.cond_true   = r_cond_true;

endmodule
